// File: rtl/fpu_round_pkg.sv
`default_nettype none
// ============================================================
// Package : fpu_round_pkg
// Purpose : shared types and constants for the rounding scheduler
// Rev     : 1.0
// ============================================================
package fpu_round_pkg;

   localparam int c_round_lat_default = 4;

   localparam logic [1:0] c_rm_nearest = 2'b00;
   localparam logic [1:0] c_rm_zero    = 2'b01;
   localparam logic [1:0] c_rm_pos_inf = 2'b10;
   localparam logic [1:0] c_rm_neg_inf = 2'b11;

   typedef struct packed {
      logic [1:0]  mode;
      logic        sign;
      logic [55:0] mantissa;
      logic [11:0] exponent;
   } round_op_t;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ROUND = 2'd1,
      ST_DONE  = 2'd2
   } sched_state_t;

endpackage
`default_nettype wire

// File: rtl/fpu_round.sv
`default_nettype none
// ============================================================
// Module  : fpu_round
// Purpose : rounds a 56-bit mantissa to a packed double, ROUND_LAT deep
// Rev     : 1.0
// ============================================================
module fpu_round
   import fpu_round_pkg::*;
#(
   parameter int ROUND_LAT = c_round_lat_default
)(
   input  logic        clk,
   input  logic        rst,
   input  logic        i_en,
   input  round_op_t   i_op,
   output logic [63:0] o_round_out,
   output logic [11:0] o_exponent_final
);

   logic        w_guard;
   logic        w_rbit;
   logic        w_inc;
   logic [54:0] w_sum;
   logic [51:0] w_frac;
   logic [1:0]  w_adj;
   logic [11:0] w_exp;
   logic [75:0] w_stage_in;
   logic [75:0] r_pipe [ROUND_LAT];

   assign w_guard = i_op.mantissa[1];
   assign w_rbit  = i_op.mantissa[0];

   // Nearest rounds a tie away from zero; directed modes consider any discarded bit.
   always_comb begin
      w_inc = 1'b0;
      case (i_op.mode)
         c_rm_nearest: w_inc = w_guard;
         c_rm_zero:    w_inc = 1'b0;
         c_rm_pos_inf: w_inc = (w_guard | w_rbit) & ~i_op.sign;
         c_rm_neg_inf: w_inc = (w_guard | w_rbit) & i_op.sign;
         default:      w_inc = 1'b0;
      endcase
   end

   assign w_sum = {1'b0, i_op.mantissa[55:2]} + {54'd0, w_inc};

   always_comb begin
      w_frac = w_sum[51:0];
      w_adj  = 2'd0;
      if (w_sum[54]) begin
         w_frac = w_sum[53:2];
         w_adj  = 2'd2;
      end else if (w_sum[53]) begin
         w_frac = w_sum[52:1];
         w_adj  = 2'd1;
      end
   end

   assign w_exp      = i_op.exponent + {10'd0, w_adj};
   assign w_stage_in = {i_op.sign, w_exp[10:0], w_frac, w_exp};

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < ROUND_LAT; i++) r_pipe[i] <= '0;
      end else if (i_en) begin
         r_pipe[0] <= w_stage_in;
         for (int i = 1; i < ROUND_LAT; i++) r_pipe[i] <= r_pipe[i-1];
      end
   end

   assign o_round_out      = r_pipe[ROUND_LAT-1][75:12];
   assign o_exponent_final = r_pipe[ROUND_LAT-1][11:0];

endmodule
`default_nettype wire

// File: rtl/fpu_round_sched.sv
`default_nettype none
// ============================================================
// Module  : fpu_round_sched
// Purpose : round-robin scheduler sharing one rounding unit among N_REQ requesters
// Rev     : 1.0
// ============================================================
module fpu_round_sched
   import fpu_round_pkg::*;
#(
   parameter int N_REQ     = 4,
   parameter int ROUND_LAT = c_round_lat_default
)(
   input  logic                                     clk,
   input  logic                                     rst,
   input  logic [N_REQ-1:0]                         req_valid,
   output logic [N_REQ-1:0]                         req_ready,
   input  logic [2*N_REQ-1:0]                       req_round_mode,
   input  logic [N_REQ-1:0]                         req_sign,
   input  logic [56*N_REQ-1:0]                      req_mantissa,
   input  logic [12*N_REQ-1:0]                      req_exponent,
   output logic                                     out_valid,
   input  logic                                     out_ready,
   output logic [63:0]                              out_result,
   output logic [11:0]                              out_exponent,
   output logic [((N_REQ > 1) ? $clog2(N_REQ) : 1)-1:0] out_id,
   output logic                                     busy
);

   localparam int c_id_w  = (N_REQ > 1) ? $clog2(N_REQ) : 1;
   localparam int c_cnt_w = $clog2(ROUND_LAT + 1);

   sched_state_t        r_state;
   sched_state_t        w_state_nxt;
   logic [c_id_w-1:0]   r_ptr;
   logic [c_cnt_w-1:0]  r_cnt;
   round_op_t           r_hold;
   logic [c_id_w-1:0]   r_hold_id;
   logic [63:0]         r_out_result;
   logic [11:0]         r_out_exponent;
   logic [c_id_w-1:0]   r_out_id;

   round_op_t           w_ops [N_REQ];
   logic [c_id_w-1:0]   w_cand;
   logic [c_id_w-1:0]   w_gidx;
   logic                w_found;
   logic [N_REQ-1:0]    w_req_ready;
   logic                w_accept;
   logic                w_cnt_done;
   logic [63:0]         w_round_out;
   logic [11:0]         w_exp_final;

   for (genvar g = 0; g < N_REQ; g++) begin : g_unpack
      assign w_ops[g] = {req_round_mode[2*g +: 2], req_sign[g],
                         req_mantissa[56*g +: 56], req_exponent[12*g +: 12]};
   end

   // Scan from farthest to nearest so the last hit is the first valid at/after the pointer.
   always_comb begin
      w_found = 1'b0;
      w_gidx  = '0;
      w_cand  = '0;
      for (int k = N_REQ - 1; k >= 0; k--) begin
         w_cand = c_id_w'((int'(r_ptr) + k) % N_REQ);
         if (req_valid[w_cand]) begin
            w_found = 1'b1;
            w_gidx  = w_cand;
         end
      end
   end

   always_comb begin
      w_req_ready = '0;
      if (!rst && r_state == ST_IDLE && w_found) w_req_ready[w_gidx] = 1'b1;
   end

   assign w_accept   = |(req_valid & w_req_ready);
   assign w_cnt_done = (r_cnt == c_cnt_w'(ROUND_LAT));

   always_ff @(posedge clk or posedge rst) begin
      if (rst) r_state <= ST_IDLE;
      else     r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         ST_IDLE:  if (w_accept)   w_state_nxt = ST_ROUND;
         ST_ROUND: if (w_cnt_done) w_state_nxt = ST_DONE;
         ST_DONE:  if (out_ready)  w_state_nxt = ST_IDLE;
         default:                  w_state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_ptr          <= '0;
         r_cnt          <= '0;
         r_hold         <= '0;
         r_hold_id      <= '0;
         r_out_result   <= '0;
         r_out_exponent <= '0;
         r_out_id       <= '0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (w_accept) begin
                  r_hold    <= w_ops[w_gidx];
                  r_hold_id <= w_gidx;
                  r_cnt     <= '0;
               end
            end
            ST_ROUND: begin
               r_cnt <= r_cnt + 1'b1;
               if (w_cnt_done) begin
                  r_out_result   <= w_round_out;
                  r_out_exponent <= w_exp_final;
                  r_out_id       <= r_hold_id;
               end
            end
            ST_DONE: begin
               if (out_ready)
                  r_ptr <= (r_out_id == c_id_w'(N_REQ - 1)) ? '0 : r_out_id + 1'b1;
            end
            default: ;
         endcase
      end
   end

   fpu_round #(
      .ROUND_LAT (ROUND_LAT)
   ) u_round (
      .clk              (clk),
      .rst              (rst),
      .i_en             (r_state == ST_ROUND),
      .i_op             (r_hold),
      .o_round_out      (w_round_out),
      .o_exponent_final (w_exp_final)
   );

   assign req_ready    = w_req_ready;
   assign out_valid    = (r_state == ST_DONE);
   assign busy         = (r_state != ST_IDLE);
   assign out_result   = r_out_result;
   assign out_exponent = r_out_exponent;
   assign out_id       = r_out_id;

endmodule
`default_nettype wire
